// File: rtl/clk_en_gen_if.sv
// rtl/clk_en_gen_if.sv - configuration strobes and clock-enable outputs of clk_en_gen
interface clk_en_gen_if #(
   parameter int NCH   = 3,
   parameter int ACC_W = 32
);
   logic             cfg_we;
   logic [2:0]       cfg_ch;
   logic [ACC_W-1:0] cfg_inc;
   logic             cfg_sync;
   logic             cfg_ack;
   logic             cfg_err;
   logic [NCH-1:0]   ce;
   logic             ready;

   modport master (
      output cfg_we, cfg_ch, cfg_inc, cfg_sync,
      input  cfg_ack, cfg_err, ce, ready
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_inc, cfg_sync,
      output cfg_ack, cfg_err, ce, ready
   );
endinterface

// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - phase-accumulator clock-enable generator gated by a settled PLL lock
module clk_en_gen #(
   parameter int NCH    = 3,
   parameter int ACC_W  = 32,
   parameter int SETTLE = 1024,
   parameter logic [NCH*ACC_W-1:0] INC_INIT = {NCH{ACC_W'(32'h4000_0000 >> (32 - ACC_W))}}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         pll_locked,
   clk_en_gen_if.slave  bus
);
   localparam int             CNT_W    = $clog2(SETTLE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
   localparam logic [3:0]     NCH_4    = 4'(NCH);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK,
      ST_SETTLE,
      ST_RUN
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             sync1, lock_s;
   logic             run_add;
   logic [ACC_W-1:0] acc [NCH];
   logic [ACC_W-1:0] inc [NCH];
   logic [ACC_W:0]   sum [NCH];
   logic [NCH-1:0]   ce_q;
   logic             ready_q, ack_q, err_q;
   logic             ch_ok;

   assign ch_ok = ({1'b0, bus.cfg_ch} < NCH_4);

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         ST_WAIT_LOCK: begin
            if (lock_s) begin
               state_next = ST_SETTLE;
               cnt_next   = '0;
            end
         end
         ST_SETTLE: begin
            if (!lock_s)
               state_next = ST_WAIT_LOCK;
            else if (cnt == CNT_LAST)
               state_next = ST_RUN;
            else
               cnt_next = cnt + CNT_W'(1);
         end
         ST_RUN: begin
            if (!lock_s)
               state_next = ST_WAIT_LOCK;
         end
         default: state_next = ST_WAIT_LOCK;
      endcase
   end

   // The leaving cycle already counts as outside RUN, so ce and ready drop together.
   assign run_add = (state == ST_RUN) && (state_next == ST_RUN);

   always_comb begin
      for (int i = 0; i < NCH; i++)
         sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b0;
         lock_s  <= 1'b0;
         state   <= ST_WAIT_LOCK;
         cnt     <= '0;
         ce_q    <= '0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            acc[i] <= '0;
            inc[i] <= INC_INIT[i*ACC_W +: ACC_W];
         end
      end else begin
         sync1   <= pll_locked;
         lock_s  <= sync1;
         state   <= state_next;
         cnt     <= cnt_next;
         ready_q <= (state_next == ST_RUN);
         ack_q   <= bus.cfg_we && ch_ok;
         err_q   <= bus.cfg_we && !ch_ok;
         for (int i = 0; i < NCH; i++) begin
            if (bus.cfg_we && (bus.cfg_ch == 3'(i)))
               inc[i] <= bus.cfg_inc;
            if (run_add && !bus.cfg_sync) begin
               acc[i]  <= sum[i][ACC_W-1:0];
               ce_q[i] <= sum[i][ACC_W];
            end else begin
               acc[i]  <= '0;
               ce_q[i] <= 1'b0;
            end
         end
      end
   end

   assign bus.ce      = ce_q;
   assign bus.ready   = ready_q;
   assign bus.cfg_ack = ack_q;
   assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_clk_en_gen.sv
// tb/tb_clk_en_gen.sv - scoreboard bench for clk_en_gen with NCH=3, ACC_W=8, SETTLE=16
module tb_clk_en_gen;
   typedef struct packed {
      logic       ready;
      logic [2:0] ce;
      logic       ack;
      logic       err;
   } exp_t;

   logic clk;
   logic rst;
   logic pll_locked;
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   exp_t got;
   exp_t sb [$];

   int m_s1, m_s2, m_st, m_cnt;
   int m_acc [3];
   int m_inc [3];

   clk_en_gen_if #(.NCH(3), .ACC_W(8)) bus ();

   clk_en_gen #(.NCH(3), .ACC_W(8), .SETTLE(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .pll_locked (pll_locked),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model advances with the edge, pushes what the DUT must show after it.
   task automatic step();
      exp_t e;
      int   nst, s;
      e = '0;
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0;
         for (int i = 0; i < 3; i++) begin
            m_acc[i] = 0;
            m_inc[i] = 64;
         end
      end else begin
         nst = m_st;
         case (m_st)
            0: if (m_s2 == 1) begin nst = 1; m_cnt = 0; end
            1: begin
               if (m_s2 == 0) nst = 0;
               else if (m_cnt == 15) nst = 2;
               else m_cnt = m_cnt + 1;
            end
            default: if (m_s2 == 0) nst = 0;
         endcase
         for (int i = 0; i < 3; i++) begin
            if (m_st == 2 && nst == 2 && !bus.cfg_sync) begin
               s = m_acc[i] + m_inc[i];
               e.ce[i] = (s >= 256);
               m_acc[i] = s % 256;
            end else begin
               m_acc[i] = 0;
            end
         end
         if (bus.cfg_we && bus.cfg_ch < 3) begin
            m_inc[int'(bus.cfg_ch)] = int'(bus.cfg_inc);
            e.ack = 1'b1;
         end
         if (bus.cfg_we && bus.cfg_ch >= 3) e.err = 1'b1;
         e.ready = (nst == 2);
         m_s2 = m_s1;
         m_s1 = int'(pll_locked);
         m_st = nst;
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = {bus.ready, bus.ce, bus.cfg_ack, bus.cfg_err};
      cyc++;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1;
      pll_locked = 1'b1;
      repeat (3) begin
         step();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", cyc, got, e); end
      end
      checks++;
      if (got !== 6'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", got, 6'b0); end
   endtask

   task automatic test_lock_settle();
      exp_t e;
      int first, pulses;
      first = -1; pulses = 0;
      rst = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         step();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL settle_model cyc=%0d got=%b exp=%b", cyc, got, e); end
         if (got.ready && first < 0) first = k;
         if (k >= 20 && k <= 35) pulses += int'(got.ce[0]);
      end
      checks++;
      if (first != 19) begin errors++; $display("FAIL ready_latency got=%0d exp=19", first); end
      checks++;
      if (pulses != 4) begin errors++; $display("FAIL default_rate got=%0d exp=4", pulses); end
   endtask

   task automatic test_rate_85();
      exp_t e;
      int pulses, adjacent;
      logic prev;
      pulses = 0; adjacent = 0; prev = 1'b0;
      bus.cfg_we = 1'b1; bus.cfg_ch = 3'd1; bus.cfg_inc = 8'h55;
      step();
      bus.cfg_we = 1'b0;
      e = sb.pop_front();
      checks++;
      if (got.ack !== 1'b1 || got.err !== 1'b0) begin errors++; $display("FAIL write_ack got=%b%b exp=10", got.ack, got.err); end
      for (int k = 0; k < 256; k++) begin
         step();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL rate85_model cyc=%0d got=%b exp=%b", cyc, got, e); end
         pulses += int'(got.ce[1]);
         if (prev && got.ce[1]) adjacent++;
         prev = got.ce[1];
      end
      checks++;
      if (pulses != 85) begin errors++; $display("FAIL rate85_count got=%0d exp=85", pulses); end
      checks++;
      if (adjacent != 0) begin errors++; $display("FAIL rate85_adjacent got=%0d exp=0", adjacent); end
   endtask

   task automatic test_bad_channel();
      exp_t e;
      int pulses;
      pulses = 0;
      bus.cfg_we = 1'b1; bus.cfg_ch = 3'd3; bus.cfg_inc = 8'h00;
      step();
      bus.cfg_we = 1'b0;
      e = sb.pop_front();
      checks++;
      if (got.err !== 1'b1 || got.ack !== 1'b0) begin errors++; $display("FAIL bad_ch_err got=%b%b exp=01", got.ack, got.err); end
      for (int k = 0; k < 16; k++) begin
         step();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL bad_ch_model cyc=%0d got=%b exp=%b", cyc, got, e); end
         pulses += int'(got.ce[0]);
      end
      checks++;
      if (pulses != 4) begin errors++; $display("FAIL bad_ch_rate got=%0d exp=4", pulses); end
   endtask

   task automatic test_sync();
      exp_t e;
      int hits, first_hit, second_hit;
      hits = 0; first_hit = -1; second_hit = -1;
      bus.cfg_we = 1'b1; bus.cfg_ch = 3'd0; bus.cfg_inc = 8'd85;
      step(); e = sb.pop_front();
      bus.cfg_ch = 3'd1; bus.cfg_inc = 8'd64;
      step(); e = sb.pop_front();
      bus.cfg_we = 1'b0;
      repeat (5) begin
         step();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL presync_model cyc=%0d got=%b exp=%b", cyc, got, e); end
      end
      bus.cfg_sync = 1'b1; bus.cfg_we = 1'b1; bus.cfg_ch = 3'd2; bus.cfg_inc = 8'd128;
      step();
      bus.cfg_sync = 1'b0; bus.cfg_we = 1'b0;
      e = sb.pop_front();
      checks++;
      if (got.ce !== 3'b000 || got.ack !== 1'b1) begin errors++; $display("FAIL sync_clear got ce=%b ack=%b exp ce=000 ack=1", got.ce, got.ack); end
      for (int k = 1; k <= 24; k++) begin
         step();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL sync_model cyc=%0d got=%b exp=%b", cyc, got, e); end
         if (got.ce[0] && got.ce[1]) begin
            hits++;
            if (first_hit < 0) first_hit = k;
            else if (second_hit < 0) second_hit = k;
         end
      end
      checks++;
      if (hits != 2 || first_hit != 4 || second_hit != 16)
         begin errors++; $display("FAIL sync_coincide got=%0d@%0d,%0d exp=2@4,16", hits, first_hit, second_hit); end
   endtask

   task automatic test_lock_loss();
      exp_t e;
      int first;
      first = -1;
      pll_locked = 1'b0;
      step(); e = sb.pop_front();
      pll_locked = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         if (k == 2) begin bus.cfg_we = 1'b1; bus.cfg_ch = 3'd2; bus.cfg_inc = 8'd32; end
         step();
         bus.cfg_we = 1'b0;
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL relock_model cyc=%0d got=%b exp=%b", cyc, got, e); end
         if (k == 2) begin
            checks++;
            if (got.ready !== 1'b0 || got.ce !== 3'b000 || got.ack !== 1'b1)
               begin errors++; $display("FAIL lock_drop got=%b exp ready=0 ce=000 ack=1", got); end
         end
         if (k > 2 && got.ready && first < 0) first = k;
      end
      checks++;
      if (first != 19) begin errors++; $display("FAIL relock_latency got=%0d exp=19", first); end
   endtask

   task automatic test_reset_mid_run();
      exp_t e;
      int zero_pulses, first, p0, p2;
      zero_pulses = 0; first = -1; p0 = 0; p2 = 0;
      bus.cfg_we = 1'b1; bus.cfg_ch = 3'd2; bus.cfg_inc = 8'd0;
      step(); e = sb.pop_front();
      bus.cfg_we = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL inc0_model cyc=%0d got=%b exp=%b", cyc, got, e); end
         zero_pulses += int'(got.ce[2]);
      end
      checks++;
      if (zero_pulses != 0) begin errors++; $display("FAIL inc0_silent got=%0d exp=0", zero_pulses); end
      rst = 1'b1; bus.cfg_we = 1'b1; bus.cfg_ch = 3'd0; bus.cfg_inc = 8'd0; bus.cfg_sync = 1'b1;
      step(); e = sb.pop_front();
      rst = 1'b0; bus.cfg_we = 1'b0; bus.cfg_sync = 1'b0;
      checks++;
      if (got !== 6'b0) begin errors++; $display("FAIL midrun_reset got=%b exp=%b", got, 6'b0); end
      for (int k = 1; k <= 40; k++) begin
         step();
         e = sb.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL postrst_model cyc=%0d got=%b exp=%b", cyc, got, e); end
         if (got.ready && first < 0) first = k;
         if (k >= 20 && k <= 35) begin p0 += int'(got.ce[0]); p2 += int'(got.ce[2]); end
      end
      checks++;
      if (first != 19) begin errors++; $display("FAIL postrst_latency got=%0d exp=19", first); end
      checks++;
      if (p2 != 4 || p0 != 4) begin errors++; $display("FAIL postrst_rates got ch0=%0d ch2=%0d exp 4,4", p0, p2); end
   endtask

   initial begin
      rst = 1'b1;
      pll_locked = 1'b1;
      bus.cfg_we = 1'b0;
      bus.cfg_ch = 3'd0;
      bus.cfg_inc = 8'd0;
      bus.cfg_sync = 1'b0;
      @(negedge clk);
      test_reset();
      test_lock_settle();
      test_rate_85();
      test_bad_channel();
      test_sync();
      test_lock_loss();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL provide parameter NCH, default 3, number of clock-enable channels (1..8).
REQ-002 SHALL provide parameter ACC_W, default 32, phase-accumulator and increment width (8..32).
REQ-003 SHALL provide parameter SETTLE, default 1024, number of clk cycles the synchronised lock must hold before output starts (>=2).
REQ-004 SHALL provide parameter INC_INIT, default all NCH fields 32'h4000_0000 (ACC_W truncated), packed reset increments, channel 0 in the LSBs.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pll_locked  in  1  PLL lock, asynchronous to clk.
REQ-008 cfg_we  in  1  one-cycle increment-write strobe.
REQ-009 cfg_ch  in  3  target channel of the write.
REQ-010 cfg_inc  in  ACC_W  new increment value.
REQ-011 cfg_sync  in  1  one-cycle strobe; phase-aligns all channels.
REQ-012 cfg_ack  out  1  one-cycle pulse, write accepted.
REQ-013 cfg_err  out  1  one-cycle pulse, write rejected (cfg_ch >= NCH).
REQ-014 ce  out  NCH  per-channel clock enables, registered.
REQ-015 ready  out  1  high while in RUN.

Function
REQ-016 pll_locked SHALL pass through a 2-flop synchroniser; lock_s is the second flop output.
REQ-017 FSM states SHALL be WAIT_LOCK, SETTLE, RUN.
REQ-018 WAIT_LOCK -> SETTLE when lock_s=1; the settle counter loads 0.
REQ-019 SETTLE: counter increments each cycle; -> RUN the cycle after the counter reaches SETTLE-1; -> WAIT_LOCK if lock_s=0.
REQ-020 RUN -> WAIT_LOCK when lock_s=0; no other exit except rst.
REQ-021 In RUN, each cycle per channel i: {carry, acc[i]} <= acc[i] + inc[i] (ACC_W+1-bit sum); ce[i] <= carry.
REQ-022 Average ce[i] rate SHALL be inc[i]/2^ACC_W of clk; inc=0 gives ce[i] constantly 0.
REQ-023 Outside RUN: ce SHALL be all 0 and every acc SHALL be held at 0.
REQ-024 On entering RUN the first accumulator add SHALL occur in the first RUN cycle; ce is valid one cycle later.
REQ-025 Writes SHALL be accepted in any FSM state: if cfg_we and cfg_ch<NCH, then inc[cfg_ch] <= cfg_inc and cfg_ack=1 the next cycle.
REQ-026 If cfg_we and cfg_ch>=NCH, then inc is unchanged and cfg_err=1 the next cycle.
REQ-027 A new increment SHALL first be used in the accumulator add of the cycle after the write; acc is not modified by a write.
REQ-028 cfg_sync in RUN SHALL load every acc to 0 and force ce to 0 on the following cycle; accumulation resumes the cycle after.
REQ-029 cfg_sync together with cfg_we SHALL perform both: the increment is updated and the accumulators are cleared.
REQ-030 cfg_sync outside RUN SHALL have no effect.
REQ-031 Loss of lock in the same cycle as cfg_we SHALL still accept the write.
REQ-032 ready SHALL be registered and equal (state==RUN).

Reset
REQ-033 rst=1 SHALL set: state WAIT_LOCK, synchroniser flops 0, settle counter 0, all acc 0, inc <= INC_INIT, ce 0, ready 0, cfg_ack 0, cfg_err 0.
REQ-034 rst asserted mid-RUN SHALL take effect on the next edge and discard any cfg_we or cfg_sync in that cycle.
REQ-035 After rst deasserts with pll_locked already high, ready SHALL rise exactly 2 (sync) + SETTLE + 1 cycles later.

Verification
REQ-036 SETTLE=16, pll_locked=1 held, rst released -> ready rises after 19 cycles; ce[0] at default INC_INIT gives 1 pulse every 4 cycles.
REQ-037 ACC_W=8, write ch1 inc=8'h55, 256 RUN cycles -> exactly 85 ce[1] pulses, no two adjacent pulses.
REQ-038 In RUN, drop pll_locked for 1 cycle -> ce=0 and ready=0 within 3 cycles; re-lock -> ready returns after 2+SETTLE+1 cycles.
REQ-039 cfg_we with cfg_ch=3, NCH=3 -> cfg_err pulse, no cfg_ack, all ce rates unchanged.
REQ-040 Channels with inc 1/3 and 1/4 rate, then cfg_sync -> ce all 0 for one cycle, then the channels coincide every 12 cycles starting from the same phase.
REQ-041 rst pulse mid-RUN after writing inc=0 on ch2 -> inc[2] restored to INC_INIT and ce[2] pulses again after relock.
